kbd_input_scheduler: RTL and testbench

//  Buffers hex words committed on the keyboard (enter strobe + 32-bit value) in a small FIFO.

---
 rtl/kbd_input_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_kbd_input_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/kbd_input_scheduler.sv
// kbd_input_scheduler
//   Buffers 32-bit words committed on the keyboard (enter strobe + value) in a
//   small circular FIFO. It serves them to the CPU MMIO input port through a
//   level request / one-cycle acknowledge handshake. waiting_o tells the LEDs
//   that the CPU is stalled on an empty FIFO.
//
// Optional feature: define KBD_TIMEOUT_EN to abandon a WAIT after
//   TIMEOUT_CYCLES cycles. On timeout the block delivers TIMEOUT_VALUE with
//   rd_ack_o and pulses timed_out_o.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   kbd_enter_i       commit strobe (asynchronous, any width)
//   kbd_value_i       committed word, stable while kbd_enter_i is high
//   rd_req_i          CPU read request (level, held until rd_ack_o)
//   rd_ack_o          one-cycle pulse, rd_data_o valid
//   rd_data_o         last delivered word (held between deliveries)
//   waiting_o         request pending on an empty FIFO
//   fifo_count_o      entries stored; fifo_empty_o / fifo_full_o flags
//   overflow_o        sticky: a commit was dropped while full
//   clr_ovf_i         clears overflow_o (a drop in the same cycle wins)
//   timed_out_o       pulse coincident with a timeout rd_ack_o
module kbd_input_scheduler #(
    parameter int unsigned DEPTH          = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000,
    parameter logic [31:0] TIMEOUT_VALUE  = 32'h0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     kbd_enter_i,
    input  logic [31:0]              kbd_value_i,
    input  logic                     rd_req_i,
    input  logic                     clr_ovf_i,
    output logic                     rd_ack_o,
    output logic [31:0]              rd_data_o,
    output logic                     waiting_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     fifo_empty_o,
    output logic                     fifo_full_o,
    output logic                     overflow_o,
    output logic                     timed_out_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2, HOLD = 2'd3} state_t;

    state_t          state_q;
    logic [31:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            overflow_q;
    logic            rd_ack_q, waiting_q, timed_out_q;
    logic [31:0]     rd_data_q;

    logic            enter_s1_q, enter_s2_q, enter_s3_q;
    logic [1:0]      settle_q;
    logic            armed_q;

    logic            push_s, pop_s, do_push_s, drop_s, empty_s, full_s;

    assign empty_s = (count_q == CW'(0));
    assign full_s  = (count_q == CW'(DEPTH));

    // Synchronize the enter strobe. The detector is armed only once the
    // synchronizer has flushed after reset and shown a low level, so a key held
    // through reset does not commit until it is released and pressed again.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enter_s1_q <= 1'b0;
            enter_s2_q <= 1'b0;
            enter_s3_q <= 1'b0;
            settle_q   <= 2'd0;
            armed_q    <= 1'b0;
        end else begin
            enter_s1_q <= kbd_enter_i;
            enter_s2_q <= enter_s1_q;
            enter_s3_q <= enter_s2_q;
            if (settle_q != 2'd2) begin
                settle_q <= settle_q + 2'd1;
            end
            if ((settle_q == 2'd2) && !enter_s2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Push on a synchronized rising edge. Pop whenever the FSM serves a request
    // from IDLE or WAIT with data present.
    always_comb begin
        push_s    = enter_s2_q & ~enter_s3_q & armed_q;
        pop_s     = rd_req_i & ~empty_s & ((state_q == IDLE) || (state_q == WAIT));
        do_push_s = push_s & (~full_s | pop_s);
        drop_s    = push_s & full_s & ~pop_s;
    end

    // FIFO storage; contents need no reset because count/pointers gate them.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= kbd_value_i;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop_s) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

`ifdef KBD_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;
`else
    logic [63:0] unused_cfg_s;
    assign unused_cfg_s = {TIMEOUT_CYCLES, TIMEOUT_VALUE};
`endif

    // Read handshake FSM with registered ack/waiting/data outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= 32'h0;
            waiting_q   <= 1'b0;
            timed_out_q <= 1'b0;
`ifdef KBD_TIMEOUT_EN
            tmo_cnt_q   <= 32'h0;
`endif
        end else begin
            rd_ack_q    <= 1'b0;
            timed_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop_s) begin
                        rd_data_q <= mem_q[rd_ptr_q];
                        rd_ack_q  <= 1'b1;
                        state_q   <= ACK;
                    end else if (rd_req_i) begin
                        waiting_q <= 1'b1;
                        state_q   <= WAIT;
`ifdef KBD_TIMEOUT_EN
                        tmo_cnt_q <= 32'h0;
`endif
                    end
                end
                WAIT: begin
                    if (!rd_req_i) begin
                        waiting_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (pop_s) begin
                        rd_data_q <= mem_q[rd_ptr_q];
                        rd_ack_q  <= 1'b1;
                        waiting_q <= 1'b0;
                        state_q   <= ACK;
`ifdef KBD_TIMEOUT_EN
                    end else if (tmo_cnt_q == (TIMEOUT_CYCLES - 32'd1)) begin
                        // FIFO is empty here, so a push landing this cycle stays queued.
                        rd_data_q   <= TIMEOUT_VALUE;
                        rd_ack_q    <= 1'b1;
                        timed_out_q <= 1'b1;
                        waiting_q   <= 1'b0;
                        state_q     <= ACK;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
`endif
                    end
                end
                ACK: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    // One pop per request: wait for the CPU to drop rd_req_i.
                    if (!rd_req_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    waiting_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign rd_ack_o     = rd_ack_q;
    assign rd_data_o    = rd_data_q;
    assign waiting_o    = waiting_q;
    assign fifo_count_o = count_q;
    assign fifo_empty_o = empty_s;
    assign fifo_full_o  = full_s;
    assign overflow_o   = overflow_q;
`ifdef KBD_TIMEOUT_EN
    assign timed_out_o  = timed_out_q;
`else
    assign timed_out_o  = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_input_scheduler.sv
// Directed self-checking bench for kbd_input_scheduler (DEPTH=4).
module tb_kbd_input_scheduler;
`ifdef KBD_TIMEOUT_EN
    localparam logic [31:0] TC = 32'd10;
`else
    localparam logic [31:0] TC = 32'd100000000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kbd_enter = 1'b0;
    logic [31:0] kbd_value = 32'h0;
    logic        rd_req = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        rd_ack, waiting, fifo_empty, fifo_full, overflow, timed_out;
    logic [31:0] rd_data;
    logic [2:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    kbd_input_scheduler #(.DEPTH(4), .TIMEOUT_CYCLES(TC), .TIMEOUT_VALUE(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .kbd_enter_i(kbd_enter), .kbd_value_i(kbd_value),
        .rd_req_i(rd_req), .clr_ovf_i(clr_ovf), .rd_ack_o(rd_ack), .rd_data_o(rd_data),
        .waiting_o(waiting), .fifo_count_o(fifo_count), .fifo_empty_o(fifo_empty),
        .fifo_full_o(fifo_full), .overflow_o(overflow), .timed_out_o(timed_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Commit one word: strobe high 3 cycles, then low 3 cycles.
    task automatic commit(input logic [31:0] v);
        kbd_value = v;
        kbd_enter = 1'b1;
        repeat (3) @(negedge clk);
        kbd_enter = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Full read handshake with a bounded wait for rd_ack.
    task automatic do_read(output logic [31:0] d);
        bit seen = 1'b0;
        d = 32'hDEAD_DEAD;
        rd_req = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rd_ack) begin
                seen = 1'b1;
                d = rd_data;
            end
        end
        check_eq("read_ack_seen", {31'h0, seen}, 32'h1);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int acks;
        repeat (3) @(negedge clk);
        // Reset state
        check_eq("rst_ack", {31'h0, rd_ack}, 32'h0);
        check_eq("rst_data", rd_data, 32'h0);
        check_eq("rst_wait", {31'h0, waiting}, 32'h0);
        check_eq("rst_count", {29'h0, fifo_count}, 32'h0);
        check_eq("rst_empty", {31'h0, fifo_empty}, 32'h1);
        check_eq("rst_full", {31'h0, fifo_full}, 32'h0);
        check_eq("rst_ovf", {31'h0, overflow}, 32'h0);
        check_eq("rst_tmo", {31'h0, timed_out}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single commit and read; held request yields a single ack
        commit(32'h1234);
        check_eq("t1_count", {29'h0, fifo_count}, 32'h1);
        rd_req = 1'b1;
        @(negedge clk);
        check_eq("t1_ack", {31'h0, rd_ack}, 32'h1);
        check_eq("t1_data", rd_data, 32'h1234);
        check_eq("t1_empty", {31'h0, fifo_empty}, 32'h1);
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            acks += int'(rd_ack);
        end
        check_eq("t1_no_2nd_ack", acks, 32'h0);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);

        // 2: request on empty FIFO, then commit
        rd_req = 1'b1;
        @(negedge clk);
        check_eq("t2_waiting", {31'h0, waiting}, 32'h1);
        @(negedge clk);
        kbd_value = 32'hBEEF;
        kbd_enter = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t2_ack_early", {31'h0, rd_ack}, 32'h0);
        check_eq("t2_count", {29'h0, fifo_count}, 32'h1);
        check_eq("t2_wait_hold", {31'h0, waiting}, 32'h1);
        @(negedge clk);
        check_eq("t2_ack", {31'h0, rd_ack}, 32'h1);
        check_eq("t2_data", rd_data, 32'hBEEF);
        check_eq("t2_wait_off", {31'h0, waiting}, 32'h0);
        kbd_enter = 1'b0;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);

        // 3: overflow with five commits into a four-entry FIFO
        for (int i = 1; i <= 5; i++) commit(i);
        check_eq("t3_full", {31'h0, fifo_full}, 32'h1);
        check_eq("t3_count", {29'h0, fifo_count}, 32'h4);
        check_eq("t3_ovf", {31'h0, overflow}, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            do_read(d);
            check_eq($sformatf("t3_read%0d", i), d, i);
        end
        check_eq("t3_empty", {31'h0, fifo_empty}, 32'h1);
        check_eq("t3_ovf_sticky", {31'h0, overflow}, 32'h1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check_eq("t3_ovf_clr", {31'h0, overflow}, 32'h0);

        // 4: long strobe gives exactly one push
        kbd_value = 32'h77;
        kbd_enter = 1'b1;
        repeat (50) @(negedge clk);
        kbd_enter = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t4_count", {29'h0, fifo_count}, 32'h1);
        do_read(d);
        check_eq("t4_data", d, 32'h77);

        // 5: simultaneous push and pop at count 2
        commit(32'hA1);
        commit(32'hB2);
        kbd_value = 32'hC3;
        kbd_enter = 1'b1;
        repeat (2) @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        check_eq("t5_count", {29'h0, fifo_count}, 32'h2);
        check_eq("t5_ack", {31'h0, rd_ack}, 32'h1);
        check_eq("t5_data", rd_data, 32'hA1);
        rd_req = 1'b0;
        kbd_enter = 1'b0;
        repeat (2) @(negedge clk);
        do_read(d);
        check_eq("t5_order_b", d, 32'hB2);
        do_read(d);
        check_eq("t5_order_c", d, 32'hC3);

        // 5b: reset in the middle of WAIT
        rd_req = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t5_wait", {31'h0, waiting}, 32'h1);
        rst = 1'b1;
        rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t5_rst_wait", {31'h0, waiting}, 32'h0);
        check_eq("t5_rst_count", {29'h0, fifo_count}, 32'h0);
        check_eq("t5_rst_ack", {31'h0, rd_ack}, 32'h0);

        // 5c: strobe held across reset must not push until re-pressed
        kbd_value = 32'h99;
        kbd_enter = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t5_held_no_push", {29'h0, fifo_count}, 32'h0);
        kbd_enter = 1'b0;
        repeat (4) @(negedge clk);
        commit(32'h55);
        check_eq("t5_repress_count", {29'h0, fifo_count}, 32'h1);
        do_read(d);
        check_eq("t5_repress_data", d, 32'h55);

`ifdef KBD_TIMEOUT_EN
        // 6: timeout after ten WAIT cycles
        rd_req = 1'b1;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            acks += int'(rd_ack);
        end
        check_eq("t6_no_early_ack", acks, 32'h0);
        @(negedge clk);
        check_eq("t6_ack", {31'h0, rd_ack}, 32'h1);
        check_eq("t6_tmo", {31'h0, timed_out}, 32'h1);
        check_eq("t6_data", rd_data, 32'h0);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
